// File: rtl/mxrv_id_pipe_pkg.sv
// mxrv_id_pipe_pkg: shared opcode constants, immediate type encoding and decoded-field record
package mxrv_id_pipe_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Everything decoded from the word except the XLEN-wide immediate
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        imm_type_e  imm_type;
        logic       illegal;
    } dec_fields_t;

endpackage

// File: rtl/mxrv_id_pipe_decode.sv
// mxrv_id_pipe_decode: pure combinational RV32I(+M) field, immediate and legality decode
module mxrv_id_pipe_decode
    import mxrv_id_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit SUPPORT_M = 1'b1
) (
    input  logic [31:0]     inst_i,
    output dec_fields_t     dec_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;

    assign opc = inst_i[6:0];
    assign f7  = inst_i[31:25];
    assign f3  = inst_i[14:12];

    // Select fields by format; unknown opcodes keep every field zero and flag illegal
    always_comb begin
        dec_o         = '0;
        imm_o         = '0;
        dec_o.opcode  = opc;
        dec_o.illegal = inst_i[1:0] != 2'b11;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                dec_o.rd       = inst_i[11:7];
                dec_o.imm_type = IMM_U;
                imm_o          = XLEN'($signed({inst_i[31:12], 12'b0}));
            end
            OPC_JAL: begin
                dec_o.rd       = inst_i[11:7];
                dec_o.imm_type = IMM_J;
                imm_o          = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_FENCE: begin
                dec_o.rd       = inst_i[11:7];
                dec_o.rs1      = inst_i[19:15];
                dec_o.funct3   = f3;
                dec_o.imm_type = IMM_I;
                imm_o          = XLEN'($signed(inst_i[31:20]));
                dec_o.illegal  = dec_o.illegal | (opc == OPC_JALR && f3 != 3'd0)
                               | (opc == OPC_LOAD && (f3 == 3'd3 || f3 >= 3'd6));
                if (opc == OPC_OP_IMM && (f3 == 3'd1 || f3 == 3'd5)) begin
                    dec_o.funct7  = f7;
                    imm_o         = XLEN'(inst_i[24:20]);
                    dec_o.illegal = dec_o.illegal | (f3 == 3'd1 ? f7 != 7'h00 : (f7 != 7'h00 && f7 != 7'h20));
                end
            end
            OPC_BRANCH: begin
                dec_o.rs1      = inst_i[19:15];
                dec_o.rs2      = inst_i[24:20];
                dec_o.funct3   = f3;
                dec_o.imm_type = IMM_B;
                imm_o          = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
                dec_o.illegal  = dec_o.illegal | f3 == 3'd2 | f3 == 3'd3;
            end
            OPC_STORE: begin
                dec_o.rs1      = inst_i[19:15];
                dec_o.rs2      = inst_i[24:20];
                dec_o.funct3   = f3;
                dec_o.imm_type = IMM_S;
                imm_o          = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
                dec_o.illegal  = dec_o.illegal | f3 > 3'd2;
            end
            OPC_OP: begin
                dec_o.rd      = inst_i[11:7];
                dec_o.rs1     = inst_i[19:15];
                dec_o.rs2     = inst_i[24:20];
                dec_o.funct3  = f3;
                dec_o.funct7  = f7;
                dec_o.illegal = dec_o.illegal
                              | (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5)
                              | (f7 == 7'h01 && !SUPPORT_M)
                              | (f7 != 7'h00 && f7 != 7'h20 && f7 != 7'h01);
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mxrv_id_pipe.sv
// mxrv_id_pipe: registered decode stage with a 2-entry output buffer and flush
module mxrv_id_pipe
    import mxrv_id_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit SUPPORT_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [31:0]     inst_data_i,
    input  logic [XLEN-1:0] inst_pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      opcode_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [2:0]      imm_type_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    dec_fields_t     dec;
    dec_fields_t     fld_q [2];
    dec_fields_t     fld_d [2];
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] imm_q [2];
    logic [XLEN-1:0] imm_d [2];
    logic [XLEN-1:0] pc_q  [2];
    logic [XLEN-1:0] pc_d  [2];
    logic [1:0]      count_q, count_d;
    logic            push, pop;

    mxrv_id_pipe_decode #(.XLEN(XLEN), .SUPPORT_M(SUPPORT_M)) u_decode (
        .inst_i (inst_data_i),
        .dec_o  (dec),
        .imm_o  (dec_imm)
    );

    // Ready depends only on the registered count, never on dec_ready_i
    assign inst_ready_o = count_q < 2'd2;
    assign dec_valid_o  = count_q != 2'd0;
    assign push         = inst_valid_i & inst_ready_o & ~flush_i;
    assign pop          = dec_valid_o & dec_ready_i;

    // Occupancy: flush wins over any push or pop
    always_comb count_d = flush_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};

    // Slot 0 is always the head; slot 1 shifts down on a pop from full
    always_comb begin
        fld_d = fld_q;
        imm_d = imm_q;
        pc_d  = pc_q;
        if (pop && count_q == 2'd2) begin
            fld_d[0] = fld_q[1];
            imm_d[0] = imm_q[1];
            pc_d[0]  = pc_q[1];
        end else if (push && (pop || count_q == 2'd0)) begin
            fld_d[0] = dec;
            imm_d[0] = dec_imm;
            pc_d[0]  = inst_pc_i;
        end else if (push) begin
            fld_d[1] = dec;
            imm_d[1] = dec_imm;
            pc_d[1]  = inst_pc_i;
        end
    end

    // Buffer state and payload registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            fld_q   <= '{default: '0};
            imm_q   <= '{default: '0};
            pc_q    <= '{default: '0};
        end else begin
            count_q <= count_d;
            fld_q   <= fld_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o       = pc_q[0];
    assign imm_o      = imm_q[0];
    assign opcode_o   = fld_q[0].opcode;
    assign rd_o       = fld_q[0].rd;
    assign rs1_o      = fld_q[0].rs1;
    assign rs2_o      = fld_q[0].rs2;
    assign funct3_o   = fld_q[0].funct3;
    assign funct7_o   = fld_q[0].funct7;
    assign imm_type_o = fld_q[0].imm_type;
    assign illegal_o  = fld_q[0].illegal;

endmodule

// File: tb/tb_mxrv_id_pipe.sv
// tb_mxrv_id_pipe: directed and randomized checks of the decode stage against a reference model
module tb_mxrv_id_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic [31:0] inst_data_i = '0;
    logic [31:0] inst_pc_i = '0;
    logic        dec_ready_i = 1'b0;
    logic        inst_ready_o, dec_valid_o, illegal_o;
    logic [31:0] pc_o, imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o, imm_type_o;
    logic        nm_inst_ready_o, nm_dec_valid_o, nm_illegal_o;
    logic [31:0] nm_pc_o, nm_imm_o;
    logic [6:0]  nm_opcode_o, nm_funct7_o;
    logic [4:0]  nm_rd_o, nm_rs1_o, nm_rs2_o;
    logic [2:0]  nm_funct3_o, nm_imm_type_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit [6:0]  opc;
        bit [4:0]  rd, rs1, rs2;
        bit [2:0]  f3;
        bit [6:0]  f7;
        int        it;
        bit [31:0] imm;
        bit        ill;
    } exp_t;

    typedef struct {
        bit [31:0] w;
        bit [31:0] pc;
    } ent_t;

    mxrv_id_pipe #(.XLEN(32), .SUPPORT_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .inst_valid_i(inst_valid_i),
        .inst_ready_o(inst_ready_o), .inst_data_i(inst_data_i), .inst_pc_i(inst_pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .pc_o(pc_o), .opcode_o(opcode_o),
        .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .imm_type_o(imm_type_o), .imm_o(imm_o), .illegal_o(illegal_o)
    );

    mxrv_id_pipe #(.XLEN(32), .SUPPORT_M(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .inst_valid_i(inst_valid_i),
        .inst_ready_o(nm_inst_ready_o), .inst_data_i(inst_data_i), .inst_pc_i(inst_pc_i),
        .dec_valid_o(nm_dec_valid_o), .dec_ready_i(dec_ready_i), .pc_o(nm_pc_o), .opcode_o(nm_opcode_o),
        .rd_o(nm_rd_o), .rs1_o(nm_rs1_o), .rs2_o(nm_rs2_o), .funct3_o(nm_funct3_o), .funct7_o(nm_funct7_o),
        .imm_type_o(nm_imm_type_o), .imm_o(nm_imm_o), .illegal_o(nm_illegal_o)
    );

    always #5 clk = ~clk;

    // Reference decode built from format tables and plain integer arithmetic
    function automatic exp_t ref_dec(bit [31:0] w, bit m);
        exp_t      e;
        int        fmt = 0;
        bit        known = 1'b1;
        bit [6:0]  opc = w[6:0];
        bit [6:0]  f7 = w[31:25];
        bit [2:0]  f3 = w[14:12];
        int        sx = w[31] ? 1 : 0;
        case (opc)
            7'h37, 7'h17: fmt = 4;
            7'h6F: fmt = 5;
            7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: fmt = 1;
            7'h63: fmt = 3;
            7'h23: fmt = 2;
            7'h33: fmt = 0;
            default: known = 1'b0;
        endcase
        e.opc = opc;
        e.it  = known ? fmt : 0;
        e.rd  = (known && fmt inside {0, 1, 4, 5}) ? w[11:7] : 5'd0;
        e.rs1 = (known && fmt inside {0, 1, 2, 3}) ? w[19:15] : 5'd0;
        e.rs2 = (known && fmt inside {0, 2, 3}) ? w[24:20] : 5'd0;
        e.f3  = (known && fmt inside {0, 1, 2, 3}) ? f3 : 3'd0;
        e.f7  = (known && fmt == 0) ? f7 : 7'd0;
        e.imm = 0;
        if (known) begin
            case (fmt)
                1: e.imm = int'(w[31:20]) - sx * 4096;
                2: e.imm = int'({w[31:25], w[11:7]}) - sx * 4096;
                3: e.imm = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - sx * 4096;
                4: e.imm = w & 32'hFFFFF000;
                5: e.imm = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - sx * (1 << 20);
                default: e.imm = 0;
            endcase
        end
        if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
            e.f7  = f7;
            e.imm = int'(w[24:20]);
        end
        e.ill = (w[1:0] != 2'b11) || !known
              || (opc == 7'h67 && f3 != 0)
              || (opc == 7'h63 && f3 inside {2, 3})
              || (opc == 7'h03 && f3 inside {3, 6, 7})
              || (opc == 7'h23 && f3 > 2)
              || (opc == 7'h13 && f3 == 1 && f7 != 0)
              || (opc == 7'h13 && f3 == 5 && !(f7 inside {7'h00, 7'h20}))
              || (opc == 7'h33 && ((f7 == 7'h20 && !(f3 inside {0, 5})) || (f7 == 7'h01 && !m)
                                   || !(f7 inside {7'h00, 7'h20, 7'h01})));
        return e;
    endfunction

    function automatic bit [31:0] rnd_inst();
        bit [6:0]  opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        bit [6:0]  f7s [3] = '{7'h00, 7'h20, 7'h01};
        bit [31:0] r = $urandom;
        if ($urandom_range(0, 7) == 0) return r;
        r[6:0] = opcs[$urandom_range(0, 10)];
        if ($urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 2)];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(bit [31:0] w, bit [31:0] pc);
        inst_valid_i = 1'b1;
        inst_data_i  = w;
        inst_pc_i    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if ({dec_valid_o, inst_ready_o} !== 2'b01) begin errors++; $display("FAIL reset_hs got %b exp 01", {dec_valid_o, inst_ready_o}); end
        checks++; if ({imm_o, pc_o, rd_o, illegal_o} !== '0) begin errors++; $display("FAIL reset_payload got %h/%h/%h/%b exp 0", imm_o, pc_o, rd_o, illegal_o); end
        #2 rst_n = 1'b1;
        tick();
        checks++; if ({dec_valid_o, inst_ready_o} !== 2'b01) begin errors++; $display("FAIL reset_release got %b exp 01", {dec_valid_o, inst_ready_o}); end
    endtask

    task automatic test_addi();
        dec_ready_i = 1'b1;
        offer(32'hFFF10093, 32'h100);
        tick();
        inst_valid_i = 1'b0;
        checks++; if (dec_valid_o !== 1'b1) begin errors++; $display("FAIL addi_latency got %b exp 1", dec_valid_o); end
        checks++; if ({rd_o, rs1_o, rs2_o, imm_type_o, illegal_o} !== {5'd1, 5'd2, 5'd0, 3'd1, 1'b0}) begin errors++; $display("FAIL addi_fields got %h exp %h", {rd_o, rs1_o, rs2_o, imm_type_o, illegal_o}, {5'd1, 5'd2, 5'd0, 3'd1, 1'b0}); end
        checks++; if ({imm_o, pc_o} !== {32'hFFFFFFFF, 32'h100}) begin errors++; $display("FAIL addi_imm got %h/%h exp ffffffff/100", imm_o, pc_o); end
        tick();
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL addi_pop got %b exp 0", dec_valid_o); end
    endtask

    task automatic test_jal_sw();
        dec_ready_i = 1'b0;
        offer(32'hFFDFF0EF, 32'h200);
        tick();
        offer(32'h00512423, 32'h204);
        tick();
        inst_valid_i = 1'b0;
        checks++; if ({rd_o, funct3_o, imm_type_o, imm_o} !== {5'd1, 3'd0, 3'd5, 32'hFFFFFFFC}) begin errors++; $display("FAIL jal_fields got %h exp %h", {rd_o, funct3_o, imm_type_o, imm_o}, {5'd1, 3'd0, 3'd5, 32'hFFFFFFFC}); end
        dec_ready_i = 1'b1;
        tick();
        checks++; if ({rd_o, rs1_o, rs2_o, imm_type_o, imm_o, pc_o} !== {5'd0, 5'd2, 5'd5, 3'd2, 32'h8, 32'h204}) begin errors++; $display("FAIL sw_fields got %h exp %h", {rd_o, rs1_o, rs2_o, imm_type_o, imm_o, pc_o}, {5'd0, 5'd2, 5'd5, 3'd2, 32'h8, 32'h204}); end
        tick();
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL sw_pop got %b exp 0", dec_valid_o); end
    endtask

    task automatic test_illegal();
        dec_ready_i = 1'b1;
        offer(32'h00000000, 32'h300);
        tick();
        inst_valid_i = 1'b0;
        checks++; if ({illegal_o, nm_illegal_o, dec_valid_o} !== 3'b111) begin errors++; $display("FAIL ill_zero got %b exp 111", {illegal_o, nm_illegal_o, dec_valid_o}); end
        tick();
        offer(32'h022081B3, 32'h304);
        tick();
        inst_valid_i = 1'b0;
        checks++; if ({illegal_o, funct7_o, imm_type_o, imm_o} !== {1'b0, 7'h01, 3'd0, 32'h0}) begin errors++; $display("FAIL mul_m1 got %h exp %h", {illegal_o, funct7_o, imm_type_o, imm_o}, {1'b0, 7'h01, 3'd0, 32'h0}); end
        checks++; if (nm_illegal_o !== 1'b1) begin errors++; $display("FAIL mul_m0 got %b exp 1", nm_illegal_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        dec_ready_i = 1'b0;
        offer(32'h00100093, 32'h10);
        tick();
        checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b exp 1", inst_ready_o); end
        offer(32'h00200113, 32'h14);
        tick();
        checks++; if (inst_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full got %b exp 0", inst_ready_o); end
        offer(32'h00300193, 32'h18);
        tick();
        checks++; if ({inst_ready_o, dec_valid_o, pc_o, rd_o} !== {1'b0, 1'b1, 32'h10, 5'd1}) begin errors++; $display("FAIL b2b_hold got %h exp %h", {inst_ready_o, dec_valid_o, pc_o, rd_o}, {1'b0, 1'b1, 32'h10, 5'd1}); end
        dec_ready_i = 1'b1;
        tick();
        checks++; if ({inst_ready_o, pc_o, rd_o} !== {1'b1, 32'h14, 5'd2}) begin errors++; $display("FAIL b2b_second got %h exp %h", {inst_ready_o, pc_o, rd_o}, {1'b1, 32'h14, 5'd2}); end
        tick();
        inst_valid_i = 1'b0;
        checks++; if ({dec_valid_o, pc_o, rd_o} !== {1'b1, 32'h18, 5'd3}) begin errors++; $display("FAIL b2b_third got %h exp %h", {dec_valid_o, pc_o, rd_o}, {1'b1, 32'h18, 5'd3}); end
        tick();
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", dec_valid_o); end
    endtask

    task automatic test_flush();
        dec_ready_i = 1'b0;
        offer(32'h00100093, 32'h40);
        tick();
        offer(32'h00200113, 32'h44);
        tick();
        offer(32'h00300193, 32'h48);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        inst_valid_i = 1'b0;
        checks++; if ({dec_valid_o, inst_ready_o} !== 2'b01) begin errors++; $display("FAIL flush_state got %b exp 01", {dec_valid_o, inst_ready_o}); end
        tick();
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop got %b exp 0", dec_valid_o); end
    endtask

    task automatic test_async_reset();
        dec_ready_i = 1'b0;
        offer(32'hFFF10093, 32'h50);
        tick();
        offer(32'h00200113, 32'h54);
        tick();
        inst_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({dec_valid_o, inst_ready_o, imm_o} !== {1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL async_rst got %h exp %h", {dec_valid_o, inst_ready_o, imm_o}, {1'b0, 1'b1, 32'h0}); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        ent_t q[$];
        exp_t e, en;
        bit   acc, pop;
        int   n_err = errors;
        rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        for (int c = 0; c < 600; c++) begin
            inst_valid_i = $urandom_range(0, 9) < 7;
            inst_data_i  = rnd_inst();
            inst_pc_i    = $urandom & 32'hFFFFFFFC;
            dec_ready_i  = $urandom_range(0, 9) < 6;
            flush_i      = $urandom_range(0, 19) == 0;
            @(negedge clk);
            checks++; if ({dec_valid_o, inst_ready_o, nm_dec_valid_o} !== {q.size() > 0, q.size() < 2, q.size() > 0}) begin errors++; $display("FAIL rnd_hs c=%0d got %b exp %b", c, {dec_valid_o, inst_ready_o, nm_dec_valid_o}, {q.size() > 0, q.size() < 2, q.size() > 0}); end
            if (q.size() > 0) begin
                e  = ref_dec(q[0].w, 1'b1);
                en = ref_dec(q[0].w, 1'b0);
                checks++; if ({pc_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, imm_type_o, imm_o, illegal_o} !== {q[0].pc, e.opc, e.rd, e.rs1, e.rs2, e.f3, e.f7, e.it[2:0], e.imm, e.ill}) begin
                    errors++;
                    $display("FAIL rnd_head c=%0d w=%h got pc=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h it=%0d imm=%h ill=%b exp pc=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h it=%0d imm=%h ill=%b",
                             c, q[0].w, pc_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, imm_type_o, imm_o, illegal_o,
                             q[0].pc, e.rd, e.rs1, e.rs2, e.f3, e.f7, e.it, e.imm, e.ill);
                end
                checks++; if (nm_illegal_o !== en.ill) begin errors++; $display("FAIL rnd_nm_ill c=%0d w=%h got %b exp %b", c, q[0].w, nm_illegal_o, en.ill); end
            end
            acc = inst_valid_i && q.size() < 2 && !flush_i;
            pop = q.size() > 0 && dec_ready_i;
            @(posedge clk);
            if (flush_i) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back('{w: inst_data_i, pc: inst_pc_i});
            end
            #1;
            if (errors - n_err > 20) break;
        end
        inst_valid_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_jal_sw();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mxrv_id_pipe.md
Name: mxrv_id_pipe

Overview:
- Registered, handshaked decode stage between fetch and execute. Parametrised in XLEN.
- Decodes all RV32I base formats (R/I/S/B/U/J), plus optional M extension.
- Produces correctly sign-extended immediates, zeroes unused fields and flags illegal encodings.
- A 2-entry output buffer lets the upstream inst_ready_o be a registered-state signal, independent of downstream ready.

Parameters:
- XLEN, 32, datapath width for imm_o and pc; imm is sign-extended to XLEN.
- SUPPORT_M, 1, when 1, funct7=0000001 on OP is legal; when 0, it is illegal.

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered entries (branch redirect)
- inst_valid_i  in  1  fetch offers an instruction
- inst_ready_o  out  1  stage can accept this cycle
- inst_data_i  in  32  raw instruction word
- inst_pc_i  in  XLEN  pc of the instruction
- dec_valid_o  out  1  head entry valid
- dec_ready_i  in  1  execute consumes head entry
- pc_o  out  XLEN  pc of head entry
- opcode_o  out  7  inst[6:0]
- rd_o, rs1_o, rs2_o  out  5 each  register indices; 0 when the format lacks the field
- funct3_o  out  3  inst[14:12]; 0 for U/J formats
- funct7_o  out  7  inst[31:25] for R format, else 0
- imm_type_o  out  3  NONE=0, I=1, S=2, B=3, U=4, J=5
- imm_o  out  XLEN  decoded immediate
- illegal_o  out  1  head entry is an illegal encoding

Behaviour:
- Reset (async, rst_n=0):
  - Buffer count=0, so dec_valid_o=0 and inst_ready_o=1.
  - All payload registers clear to 0.
- Accept: inst_valid_i & inst_ready_o & !flush_i.
  - The decoded entry is written to the tail.
  - Latency is exactly 1 cycle: the entry is visible on dec_valid_o the cycle after acceptance if the buffer was empty.
- Pop: dec_valid_o & dec_ready_i removes the head entry.
- inst_ready_o = (count < 2). It is derived only from registered count, with no combinational path from dec_ready_i.
- Simultaneous push and pop with count=1: count stays 1 and the new entry becomes head next cycle. Entry order is strictly preserved.
- Full (count=2): inst_ready_o=0 and the input is ignored. A pop in that cycle does not enable a push in the same cycle.
- flush_i=1:
  - Next cycle, count=0 and dec_valid_o=0.
  - Any same-cycle input is dropped, and any same-cycle pop is irrelevant.
  - Flush has priority over push and pop.
- Decoded outputs are stable while dec_valid_o=1 & dec_ready_i=0.
- Immediates, all sign-extended from inst[31] to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - U: {inst[31:12], 12'b0}, sign-extended when XLEN > 32.
  - OP-IMM shifts: imm_o = zero-extended inst[24:20], with funct7_o = inst[31:25].
- Opcode to format:
  - LUI/AUIPC = U; JAL = J; JALR/LOAD/OP-IMM/SYSTEM/FENCE = I.
  - BRANCH = B; STORE = S; OP = R (imm_type NONE, imm_o=0).
- illegal_o=1 if any of the following holds; the entry is still delivered and fields are decoded best-effort:
  - inst[1:0] != 2'b11.
  - Unknown opcode.
  - JALR funct3 != 0.
  - BRANCH funct3 in {2, 3}.
  - LOAD funct3 in {3, 6, 7}.
  - STORE funct3 > 2.
  - SLLI with inst[31:25] != 0.
  - SRLI/SRAI with inst[31:25] not in {0x00, 0x20}.
  - OP with funct7 = 0x20 and funct3 not in {0, 5}.
  - OP with funct7 = 0x01 and SUPPORT_M=0.
  - OP with any other funct7 value besides 0x00, 0x20 and 0x01.

Decomposition:
- Opcode macros (INST_LUI, INST_JAL, INST_TYPE_I, …) and IMM_TYPE_* encodings go in the shared defines header.
- Combinational sub-module mxrv_id_decode holds the pure decode.
- mxrv_id_pipe adds the 2-entry buffer, count, handshake and flush.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), dec_ready_i=1 -> next cycle: rd=1, rs1=2, rs2=0, imm_type=1, imm_o=0xFFFFFFFF, illegal=0.
- jal x1,-4 (0xFFDFF0EF) -> rd=1, funct3=0, imm_type=5, imm_o=0xFFFFFFFC. sw x5,8(x2) (0x00512423) -> rs1=2, rs2=5, rd=0, imm_o=0x8.
- Illegal encodings:
  - 0x00000000 -> illegal=1.
  - mul x3,x1,x2 (0x022081B3) with SUPPORT_M=0 -> illegal=1.
  - Same word with SUPPORT_M=1 -> illegal=0, funct7=0x01.
- dec_ready_i=0, offer 3 back-to-back instructions -> first two accepted, inst_ready_o=0 from the cycle after the second accept. Then raise dec_ready_i -> outputs in order, third accepted only after count<2.
- Buffer holds 2 entries while inst_valid_i=1 and flush_i=1 in the same cycle -> next cycle dec_valid_o=0, inst_ready_o=1, offered instruction not delivered.
- Assert rst_n=0 mid-stream with count=2 -> dec_valid_o=0 immediately (async), inst_ready_o=1, imm_o=0.
